bin_line_decoder: RTL and testbench
===================================

Name: bin_line_decoder

Overview:
- Sequential counterpart to the team's 8-line priority encoder.
- Accepts a binary line index over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles.
- Keeps a sticky record of every line it has driven.
- Sits downstream of the encoder, turning an encoded request index back into a per-line strobe/grant.

Parameters:
- IN_W, 3, index width in bits; legal range 1..5.
- OUT_W, 2**IN_W, one-hot output width; derived, never overridden.
- HOLD, 4, number of cycles out_line/out_valid stay asserted per accepted index; legal range 1..255 (0 is illegal).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_bin is valid
- in_ready  output  1  decoder can accept an index this cycle
- in_bin  input  IN_W  binary line index
- out_line  output  OUT_W  one-hot decoded line, all-zero when idle
- out_valid  output  1  out_line is being driven
- out_ack  input  1  downstream acknowledge; used only with DECODER_ACK_EN
- served  output  OUT_W  sticky mask of lines driven since last clear
- clr_served  input  1  clears served
- busy  output  1  equals ~in_ready

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous and active-high. While rst is sampled high:
  - state = IDLE, out_line = 0, out_valid = 0, served = 0, hold counter = 0.
  - in_ready = 1 in the first cycle after rst deasserts.
  - Reset mid-DRIVE or mid-WAIT aborts immediately; the aborted line never marks served.
- States: IDLE, DRIVE, WAIT (WAIT exists only with DECODER_ACK_EN).
- in_ready = 1 only in IDLE. All outputs are registered.
- Accept: in IDLE with in_valid = 1 there is a transfer. Next cycle:
  - state = DRIVE, out_line = 1 << in_bin, out_valid = 1, counter = HOLD-1.
  - Latency from accept edge to out_valid is 1 cycle.
- in_bin is sampled only on the transfer cycle. Changes to in_bin while busy have no effect.
- DRIVE: counter decrements each cycle. On the cycle counter == 0, the next state is IDLE, or WAIT when the feature is enabled.
- Timing:
  - out_valid is high for exactly HOLD consecutive cycles (feature off).
  - Minimum spacing between accepts is HOLD+1 cycles.
  - No overlap: in_ready stays 0 during the final DRIVE cycle.
- Outputs return to all-zero on the IDLE entry cycle.
- out_line is always one-hot while out_valid = 1 and all-zero while out_valid = 0.
- served:
  - served[k] sets on the first DRIVE cycle of line k.
  - clr_served = 1 zeroes served on the next edge.
  - If clr_served coincides with a set, the bit being set ends at 1 and all other bits end at 0.
  - Re-driving an already-served line leaves served unchanged.
- Width: any IN_W-bit index is legal; there is no out-of-range case. The counter is 8 bits.
- in_valid while busy: ignored. The upstream must hold in_valid until in_ready.

Optional Feature:
- Macro: DECODER_ACK_EN.
- Defined:
  - After the last DRIVE cycle the decoder enters WAIT and holds out_line/out_valid until out_ack = 1 is sampled; the next cycle is IDLE.
  - out_ack sampled on the final DRIVE cycle skips WAIT and goes directly to IDLE.
  - out_ack earlier in DRIVE is ignored.
- Undefined: the WAIT state and its logic are absent, out_ack is unused, and timing is exactly HOLD cycles.

Test Plan:
- Reset then idle: assert rst 2 cycles -> out_line = 8'h00, out_valid = 0, served = 8'h00, in_ready = 1 one cycle after rst drops.
- Single decode, HOLD=4: in_bin = 3'd5 with in_valid at cycle 0 ->
  - out_line = 8'h20 and out_valid = 1 on cycles 1-4, 0 on cycle 5.
  - in_ready = 0 on cycles 1-4.
  - served = 8'h20 from cycle 1.
- Full sweep: indices 0..7 back-to-back with in_valid held -> accepts spaced exactly 5 cycles, out_line = 8'h01, 8'h02 .. 8'h80 in order, served = 8'hFF at end.
- Busy rejection: in_bin = 2 accepted, then in_bin changed to 7 with in_valid held during DRIVE -> out_line stays 8'h04 until IDLE, then 8'h80 is accepted.
- Clear collision: clr_served asserted on the same edge as line 3's first DRIVE cycle, with served previously 8'h81 -> served = 8'h08.
- Reset mid-DRIVE: rst on DRIVE cycle 2 of in_bin = 6 -> next cycle out_line = 0, out_valid = 0, served = 0.
- DECODER_ACK_EN defined: in_bin = 1, out_ack raised 3 cycles after the last DRIVE cycle -> out_valid high for HOLD+3 cycles, IDLE the cycle after ack.
- DECODER_ACK_EN defined: ack on the final DRIVE cycle -> exactly HOLD cycles.

Source files
------------

// File: rtl/bin_line_decoder_if.sv
// bin_line_decoder_if: valid/ready index input and one-hot line output of the binary line decoder.
`default_nettype none

interface bin_line_decoder_if #(
  parameter int IN_W = 3
) ();
  localparam int OUT_W = 2 ** IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_bin;
  logic [OUT_W-1:0] out_line;
  logic             out_valid;
  logic             out_ack;

  modport slave (
    input  in_valid, in_bin, out_ack,
    output in_ready, out_line, out_valid
  );

  modport master (
    output in_valid, in_bin, out_ack,
    input  in_ready, out_line, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/bin_line_decoder.sv
// bin_line_decoder: accepts a binary index and drives its one-hot line for HOLD cycles, tracking a sticky served mask.
// Optional macro DECODER_ACK_EN adds a WAIT state that holds the line until out_ack.
`default_nettype none

module bin_line_decoder #(
  parameter int IN_W = 3,
  parameter int HOLD = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  bin_line_decoder_if.slave    bus,
  output logic [2**IN_W-1:0]   served,
  input  wire logic            clr_served,
  output logic                 busy
);

  localparam int OUT_W = 2 ** IN_W;

`ifdef DECODER_ACK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1} state_t;
  logic w_unused_ack;
  assign w_unused_ack = bus.out_ack;
`endif

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [OUT_W-1:0] r_out_line;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;
  logic [OUT_W-1:0] r_served;
  logic [OUT_W-1:0] w_dec;

  assign w_dec         = OUT_W'(1) << bus.in_bin;
  assign bus.out_line  = r_out_line;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;
  assign busy          = r_busy;
  assign served        = r_served;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_out_line  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_served    <= '0;
    end else begin
      if (clr_served) begin
        r_served <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_state     <= S_DRIVE;
            r_cnt       <= 8'(HOLD - 1);
            r_out_line  <= w_dec;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            // A coincident clear drops old bits but keeps the line being set now
            r_served    <= (clr_served ? '0 : r_served) | w_dec;
          end
        end
        S_DRIVE: begin
          if (r_cnt == 8'd0) begin
`ifdef DECODER_ACK_EN
            if (bus.out_ack) begin
              r_state     <= S_IDLE;
              r_out_line  <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= S_WAIT;
            end
`else
            r_state     <= S_IDLE;
            r_out_line  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
`ifdef DECODER_ACK_EN
        S_WAIT: begin
          if (bus.out_ack) begin
            r_state     <= S_IDLE;
            r_out_line  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_out_line  <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin_line_decoder.sv
// tb_bin_line_decoder: directed checks of bin_line_decoder with IN_W=3, HOLD=4.
`default_nettype none

module tb_bin_line_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_served = 1'b0;
  logic [7:0] served;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  bin_line_decoder_if #(.IN_W(3)) bus ();

  bin_line_decoder #(.IN_W(3), .HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .served     (served),
    .clr_served (clr_served),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decode(input logic [2:0] idx);
    bus.in_bin   = idx;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] exp_line;
    int         vcount;
    bus.in_valid = 1'b0;
    bus.in_bin   = 3'd0;
    bus.out_ack  = 1'b0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_line", {24'd0, bus.out_line}, 32'h00);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_served", {24'd0, served}, 32'h00);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single decode of index 5
    bus.in_bin   = 3'd5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("single_line_c%0d", c), {24'd0, bus.out_line}, 32'h20);
      chk($sformatf("single_valid_c%0d", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("single_ready_c%0d", c), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("single_served_c%0d", c), {24'd0, served}, 32'h20);
      if (c < 4) tick();
    end
    tick();
    chk("single_c5_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("single_c5_line", {24'd0, bus.out_line}, 32'h00);
    chk("single_c5_ready", {31'd0, bus.in_ready}, 32'd1);

    // Full sweep with in_valid held: accepts every 5 cycles
    bus.in_bin   = 3'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_line = 8'h01 << i;
      chk($sformatf("sweep_line_%0d", i), {24'd0, bus.out_line}, {24'd0, exp_line});
      bus.in_bin = 3'(i + 1);
      repeat (3) tick();
      chk($sformatf("sweep_busy_%0d", i), {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk($sformatf("sweep_ready_%0d", i), {31'd0, bus.in_ready}, 32'd1);
      if (i == 7) bus.in_valid = 1'b0;
    end
    chk("sweep_served", {24'd0, served}, 32'hFF);

    // Busy rejection: index change during DRIVE is ignored
    bus.in_bin   = 3'd2;
    bus.in_valid = 1'b1;
    tick();
    bus.in_bin = 3'd7;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("busy_line_c%0d", c), {24'd0, bus.out_line}, 32'h04);
      if (c < 4) tick();
    end
    tick();
    chk("busy_idle_line", {24'd0, bus.out_line}, 32'h00);
    chk("busy_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("busy_next_line", {24'd0, bus.out_line}, 32'h80);
    repeat (4) tick();

    // Clear collision with served = 8'h81
    clr_served = 1'b1;
    tick();
    clr_served = 1'b0;
    chk("clr_plain", {24'd0, served}, 32'h00);
    decode(3'd0);
    decode(3'd7);
    chk("clr_pre", {24'd0, served}, 32'h81);
    bus.in_bin   = 3'd3;
    bus.in_valid = 1'b1;
    clr_served   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    clr_served   = 1'b0;
    chk("clr_collision", {24'd0, served}, 32'h08);
    chk("clr_line", {24'd0, bus.out_line}, 32'h08);
    repeat (4) tick();

    // Reset mid-DRIVE
    bus.in_bin   = 3'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("middrive_line", {24'd0, bus.out_line}, 32'h40);
    rst = 1'b1;
    tick();
    chk("middrive_rst_line", {24'd0, bus.out_line}, 32'h00);
    chk("middrive_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("middrive_rst_served", {24'd0, served}, 32'h00);
    rst = 1'b0;
    tick();
    chk("middrive_ready", {31'd0, bus.in_ready}, 32'd1);

`ifdef DECODER_ACK_EN
    // Ack three cycles after the final DRIVE cycle
    bus.in_bin   = 3'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vcount = 0;
    for (int c = 1; c <= 7; c++) begin
      if (bus.out_valid) vcount++;
      if (c == 7) bus.out_ack = 1'b1;
      tick();
    end
    bus.out_ack = 1'b0;
    chk("ack_wait_count", 32'(vcount), 32'd7);
    chk("ack_wait_idle", {31'd0, bus.in_ready}, 32'd1);
    chk("ack_wait_valid", {31'd0, bus.out_valid}, 32'd0);

    // Ack on the final DRIVE cycle skips WAIT
    bus.in_bin   = 3'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vcount = 0;
    for (int c = 1; c <= 4; c++) begin
      if (bus.out_valid) vcount++;
      if (c == 4) bus.out_ack = 1'b1;
      tick();
    end
    bus.out_ack = 1'b0;
    chk("ack_final_count", 32'(vcount), 32'd4);
    chk("ack_final_valid", {31'd0, bus.out_valid}, 32'd0);
`else
    vcount = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
